// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: register offsets, status bit positions and FSM state types for uart_mmio
package uart_mmio_pkg;
   localparam logic [3:0] OFF_STATUS = 4'h0;
   localparam logic [3:0] OFF_RXDATA = 4'h4;
   localparam logic [3:0] OFF_TXDATA = 4'h8;
   localparam logic [3:0] OFF_RXPOP  = 4'hC;
   localparam int ST_RX_VALID  = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_TX_FULL   = 2;
   localparam int ST_TX_IDLE   = 3;
   localparam int ST_OVERRUN   = 4;
   localparam int ST_FRAME_ERR = 5;
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_mmio_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a pop frees a full slot for a push at the same edge
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk1,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = wp == {~rp[AW], rp[AW-1:0]};
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout = mem[rp[AW-1:0]];
   always_ff @(posedge clk1) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop) rp <= rp + 1'b1;
      end
   end
   always_ff @(posedge clk1) begin
      if (do_push) mem[wp[AW-1:0]] <= din;
   end
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TX/RX FIFOs on the core data-memory port
module uart_mmio
   import uart_mmio_pkg::*;
#(
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          TX_DEPTH     = 16,
   parameter int          RX_DEPTH     = 16
) (
   input  logic        clk1,
   input  logic        reset,
   input  logic        mem_write,
   input  logic [31:0] alu_result,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        mmio_hit,
   input  logic        rxd,
   output logic        txd
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   tx_state_t tx_state;
   rx_state_t rx_state;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [2:0] tx_bit, rx_bit;
   logic [7:0] tx_sh, rx_sh, tx_head, rx_head;
   logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
   logic tx_push, tx_pop, rx_push, rx_pop, st_wr, frame_bad;
   logic rx_s1, rx_s2, rx_s3, frame_err, overrun;
   logic [3:0] off;
   logic [31:0] status;
   logic unused;
   assign unused = ^{alu_result[1:0], write_data[31:8]};
   assign mmio_hit = alu_result[31:4] == MMIO_BASE[31:4];
   assign off = {alu_result[3:2], 2'b00};
   assign st_wr = mem_write && mmio_hit && off == OFF_STATUS;
   assign tx_push = mem_write && mmio_hit && off == OFF_TXDATA;
   assign rx_pop = mem_write && mmio_hit && off == OFF_RXPOP;
   assign tx_pop = !tx_empty && (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == LAST));
   assign rx_push = rx_state == RX_STOP && rx_cnt == LAST && rx_s2;
   assign frame_bad = rx_state == RX_STOP && rx_cnt == LAST && !rx_s2;
   assign tx_idle = tx_state == TX_IDLE && tx_empty;
   sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) tx_fifo (
      .clk1(clk1), .reset(reset), .push(tx_push), .pop(tx_pop), .din(write_data[7:0]),
      .dout(tx_head), .full(tx_full), .empty(tx_empty)
   );
   sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) rx_fifo (
      .clk1(clk1), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh),
      .dout(rx_head), .full(rx_full), .empty(rx_empty)
   );
   // a pop in IDLE or at the end of STOP starts the next frame at that same edge
   always_ff @(posedge clk1) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         txd <= 1'b1;
         tx_cnt <= '0;
         tx_bit <= '0;
         tx_sh <= '0;
      end else begin
         tx_cnt <= (tx_state == TX_IDLE || tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
         case (tx_state)
            TX_START, TX_DATA: if (tx_cnt == LAST) begin
               tx_state <= (tx_state == TX_DATA && tx_bit == 3'd7) ? TX_STOP : TX_DATA;
               txd <= (tx_state == TX_DATA && tx_bit == 3'd7) ? 1'b1 : tx_sh[0];
               tx_sh <= tx_sh >> 1;
               tx_bit <= tx_state == TX_START ? 3'd0 : tx_bit + 3'd1;
            end
            TX_STOP: if (tx_cnt == LAST) tx_state <= TX_IDLE;
            default: ;
         endcase
         if (tx_pop) begin
            tx_state <= TX_START;
            txd <= 1'b0;
            tx_sh <= tx_head;
         end
      end
   end
   always_ff @(posedge clk1) begin
      if (!reset) begin
         {rx_s1, rx_s2, rx_s3} <= 3'b111;
         rx_state <= RX_IDLE;
         rx_cnt <= '0;
         rx_bit <= '0;
         rx_sh <= '0;
      end else begin
         {rx_s1, rx_s2, rx_s3} <= {rxd, rx_s1, rx_s2};
         rx_cnt <= rx_cnt + 1'b1;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (rx_s3 && !rx_s2) rx_state <= RX_START;
            end
            RX_START: if (rx_cnt == HALF) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt == LAST) begin
               rx_cnt <= '0;
               rx_sh <= {rx_s2, rx_sh[7:1]};
               rx_bit <= rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end
            RX_STOP: if (rx_cnt == LAST) rx_state <= RX_IDLE;
         endcase
      end
   end
   // sticky flags: a set in the same cycle as a clear wins
   always_ff @(posedge clk1) begin
      if (!reset) begin
         overrun <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun <= (rx_push && rx_full && !rx_pop) || (overrun && !(st_wr && write_data[4]));
         frame_err <= frame_bad || (frame_err && !(st_wr && write_data[5]));
      end
   end
   always_comb begin
      status = '0;
      status[ST_RX_VALID] = !rx_empty;
      status[ST_RX_FULL] = rx_full;
      status[ST_TX_FULL] = tx_full;
      status[ST_TX_IDLE] = tx_idle;
      status[ST_OVERRUN] = overrun;
      status[ST_FRAME_ERR] = frame_err;
   end
   assign read_data = !mmio_hit ? 32'h0 :
                      off == OFF_STATUS ? status :
                      off == OFF_RXDATA ? {24'h0, rx_empty ? 8'h0 : rx_head} : 32'h0;
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed, table-driven self-checking bench for uart_mmio (4 clocks per bit, depth 4)
module tb_uart_mmio;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
   logic clk1 = 1'b0, reset = 1'b0, mem_write = 1'b0, rxd = 1'b1;
   logic [31:0] alu_result = '0, write_data = '0;
   logic [31:0] read_data;
   logic mmio_hit, txd;
   int n_checks = 0, n_fail = 0;
   logic [31:0] d;
   logic h;
   typedef struct { logic [31:0] addr; logic hit; logic [31:0] data; } rd_vec_t;
   rd_vec_t vecs [8];
   logic [7:0] tx_bytes [6];

   uart_mmio #(.MMIO_BASE(BASE), .CLKS_PER_BIT(4), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk1(clk1), .reset(reset), .mem_write(mem_write), .alu_result(alu_result),
      .write_data(write_data), .read_data(read_data), .mmio_hit(mmio_hit), .rxd(rxd), .txd(txd)
   );

   always #5 clk1 = ~clk1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk1);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] v);
      mem_write = 1'b1;
      alu_result = a;
      write_data = v;
      tick(1);
      mem_write = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] dv, output logic hv);
      alu_result = a;
      #1;
      dv = read_data;
      hv = mmio_hit;
   endtask

   task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] dv;
      logic hv;
      rd(a, dv, hv);
      check(name, dv, exp);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      tick(4);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(4);
      end
      rxd = stop;
      tick(4);
      rxd = 1'b1;
   endtask

   function automatic logic tx_exp(input logic [7:0] b, input int pos);
      return pos < 4 ? 1'b0 : pos >= 36 ? 1'b1 : b[pos/4 - 1];
   endfunction

   initial begin
      vecs = '{'{BASE,          1'b1, 32'h8}, '{BASE + 32'h3,  1'b1, 32'h8},
               '{BASE + 32'h4,  1'b1, 32'h0}, '{BASE + 32'h8,  1'b1, 32'h0},
               '{BASE + 32'hC,  1'b1, 32'h0}, '{BASE + 32'h10, 1'b0, 32'h0},
               '{32'hFFFE_0000, 1'b0, 32'h0}, '{32'h0000_0000, 1'b0, 32'h0}};
      tx_bytes = '{8'h01, 8'h80, 8'hC3, 8'h3C, 8'h7E, 8'h00};
      tick(3);
      reset = 1'b1;
      check("reset txd", 32'(txd), 32'h1);
      for (int i = 0; i < 8; i++) begin
         rd(vecs[i].addr, d, h);
         check($sformatf("vec%0d data", i), d, vecs[i].data);
         check($sformatf("vec%0d hit", i), 32'(h), 32'(vecs[i].hit));
      end
      // reset in the middle of a frame with a byte still queued
      store(BASE + 32'h8, 32'h00);
      store(BASE + 32'h8, 32'h00);
      tick(3);
      check("tx mid-frame low", 32'(txd), 32'h0);
      reset = 1'b0;
      tick(1);
      check("mid-frame reset txd", 32'(txd), 32'h1);
      reset = 1'b1;
      chk_reg("status after reset", BASE, 32'h8);
      tick(8);
      check("txd stays idle after reset", 32'(txd), 32'h1);
      // single byte 0xA5
      store(BASE + 32'h8, 32'hA5);
      tick(1);
      for (int i = 0; i < 40; i++) begin
         check($sformatf("A5 txd pos%0d", i), 32'(txd), 32'(tx_exp(8'hA5, i)));
         tick(1);
      end
      chk_reg("tx_idle after A5", BASE, 32'h8);
      // one byte in flight then five more stores: the last overflows the FIFO
      for (int k = 0; k < 6; k++) store(BASE + 32'h8, 32'(tx_bytes[k]));
      chk_reg("tx_full", BASE, 32'h4);
      for (int i = 4; i <= 200; i++) begin
         check($sformatf("burst txd idx%0d", i), 32'(txd),
               32'(i < 200 ? tx_exp(tx_bytes[i/40], i % 40) : 1'b1));
         tick(1);
      end
      chk_reg("tx idle after burst", BASE, 32'h8);
      // RX single byte, then ignored store to RX_DATA, then pop
      send_frame(8'h3C, 1'b1);
      tick(2);
      chk_reg("rx_valid", BASE, 32'h9);
      chk_reg("rx_data 3C", BASE + 32'h4, 32'h3C);
      store(BASE + 32'h4, 32'hFF);
      chk_reg("rx_data after store to 0x4", BASE + 32'h4, 32'h3C);
      store(BASE + 32'hC, 32'h0);
      chk_reg("status after pop", BASE, 32'h8);
      chk_reg("rx_data empty", BASE + 32'h4, 32'h0);
      // overrun
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      send_frame(8'h55, 1'b1);
      tick(2);
      chk_reg("overrun status", BASE, 32'h1B);
      chk_reg("rx head after overrun", BASE + 32'h4, 32'h11);
      store(BASE, 32'h10);
      chk_reg("overrun cleared", BASE, 32'h0B);
      // pop coincides with push while full
      send_frame(8'h66, 1'b1);
      store(BASE + 32'hC, 32'h0);
      chk_reg("push+pop when full", BASE, 32'h0B);
      chk_reg("head 22", BASE + 32'h4, 32'h22);
      store(BASE + 32'hC, 32'h0);
      chk_reg("head 33", BASE + 32'h4, 32'h33);
      store(BASE + 32'hC, 32'h0);
      chk_reg("head 44", BASE + 32'h4, 32'h44);
      store(BASE + 32'hC, 32'h0);
      chk_reg("head 66", BASE + 32'h4, 32'h66);
      store(BASE + 32'hC, 32'h0);
      store(BASE + 32'hC, 32'h0);
      chk_reg("rx drained", BASE, 32'h8);
      // glitch and framing error
      rxd = 1'b0;
      tick(1);
      rxd = 1'b1;
      tick(10);
      chk_reg("glitch ignored", BASE, 32'h8);
      send_frame(8'h5A, 1'b0);
      tick(2);
      chk_reg("frame_err", BASE, 32'h28);
      chk_reg("bad frame not pushed", BASE + 32'h4, 32'h0);
      store(BASE, 32'h20);
      chk_reg("frame_err cleared", BASE, 32'h8);
      // store outside the window
      store(32'h0000_0008, 32'h55);
      rd(32'h0000_0008, d, h);
      check("non-window hit", 32'(h), 32'h0);
      check("non-window data", d, 32'h0);
      tick(3);
      check("non-window no tx", 32'(txd), 32'h1);
      chk_reg("non-window status", BASE, 32'h8);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
